risc_datapath: RTL and testbench
================================

// Module: risc_datapath
// PURPOSE
// - 16-bit single-cycle RISC datapath: PC, instruction memory, 8x16 register file, ALU, data memory, OutR register.
// - Driven cycle-by-cycle by an external control unit through decoded control inputs.
// - Test mode (test_normal=1) lets a host preload instruction and data memories before execution.
// PARAMETERS
// - IMEM_AW  8  instruction-memory address bits; depth 2**IMEM_AW; upper PC/address bits ignored.
// - DMEM_AW  8  data-memory address bits; depth 2**DMEM_AW.
// PORTS
// - clk  in  1  single clock; all state updates on rising edge.
// - clr  in  1  synchronous, active-high reset.
// - test_normal  in  1  1=test/load mode, 0=normal execution.
// - ext_instr_we / ext_instr_addr / ext_instr_data  in  1/16/16  host instruction-memory write (test mode only).
// - ext_data_write_en / ext_data_addr / ext_data_data  in  1/16/16  host data-memory write (test mode only).
// - flag_HLT  in  1  1=run, 0=halt: PC, RF, flags, dmem and OutR all hold.
// - Src_Read_B  in  1  read-port-B address: 0=Rn[4:2], 1=Rd[10:8].
// - Src_ALU_B  in  1  ALU operand B: 0=port B, 1=zero-extended imm5[4:0].
// - SUB, ADC, SBB  in  1  ALU op select (priority SUB>SBB>ADC; none=ADD).
// - JMP, flag_label_PC, flag_Rm_PC, flag_Rd_PC, BRANCH  in  1  next-PC select.
// - data_write_en  in  1  data-memory write.
// - flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI  in  1  RF write-data select.
// - RF_write_en  in  1  RF write enable.
// - flag_OutR  in  1  load OutR.
// - mem_instr_out  out  16  instruction at imem[PC] (combinational).
// - Pre_C, Pre_V, Pre_Z, Pre_N  out  1  registered ALU flags.
// - OutR  out  16  output register.
// BEHAVIOUR
// - Fields: Rd=[10:8], Rm=[7:5], Rn=[4:2], imm5=[4:0], imm8=[7:0], label=[10:0]. Port A always reads R[Rm].
// - ALU (A=R[Rm], B per Src_ALU_B): ADD A+B; SUB A+~B+1; ADC A+B+C; SBB A+~B+C.
// - ALU flags: C=carry out; V=signed overflow; Z=(result==0); N=result[15].
// - Memory reads are combinational. dmem address = ALU result; dmem write data = port B.
// - Normal-mode commit (test_normal=0, flag_HLT=1, clr=0), one instruction per edge:
// -   RF[Rd] written if RF_write_en|LHI|LLI.
// -   RF write data, priority LHI>LLI>mem>ALU>Rm>PC: {imm8,R[Rd][7:0]}; {8'h00,imm8}; dmem; ALU; R[Rm]; PC+1.
// -   dmem[addr] <= port B if data_write_en. OutR <= R[Rm] if flag_OutR.
// -   Flags updated when flag_ALU_RF=1.
// -   Next PC: JMP & flag_label_PC -> zext(label); JMP & flag_Rm_PC -> R[Rm]; JMP & flag_Rd_PC -> R[Rd] (port B).
// -   Otherwise BRANCH -> PC+sext(imm8); otherwise PC+1. PC wraps modulo 2**16.
// - Test mode: PC, RF, flags, OutR hold; internal writes suppressed; host writes land at ext addresses.
// - mem_instr_out reads imem[PC] in both modes.
// - clr (any mode): PC=0, R0..R7=0, flags=0, OutR=0; memories keep their contents. clr beats every other action.
// CONFIGURATION
// - RISC_FLAGS_EN defined: flag register as specified; ADC/SBB use the registered C.
// - RISC_FLAGS_EN undefined: no flag register; Pre_* tied 0; ADC behaves as ADD, SBB as A+~B.
// STRUCTURE
// - Package risc_pkg: field bit positions, register count, ALU op enum, IMEM/DMEM default widths.
// - One sub-module risc_alu: 16-bit adder/subtractor plus flag generation.
// - PC, RF, memories and muxes stay in the top level.
// TESTING
// - Preload imem[0]=LDR R1,[R0,#0], imem[1]=OUT R1, dmem[0]=0x1234; clr; LDR then OUT -> OutR=0x1234.
// - Add dmem[1]=0x4321 and load it into R2:
// -   ADD R3=R1+R2 -> OutR=0x5555.
// -   SUB R3=R2-R1 -> OutR=0x30ED, Pre_C=1, Pre_Z=0.
// - ADDI R2=R1+7 -> 0x123B; SUBI R2=R1-7 -> 0x122D.
// - JAL1 at PC=1, imm8=7 -> PC=8, R2=0x0002. JMP label=8 at PC=1 -> PC=8.
// - JAL2 with R1=0x12 -> PC=0x12. JR with R1=0x12 -> PC=0x12.
// - STR R1 to dmem[1], LDR R2 -> OutR=0x1234.
// - flag_HLT=0 -> PC and OutR frozen across 3 edges. clr mid-run -> PC=0, OutR=0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit single-cycle RISC datapath:
// instruction field positions, register-file geometry, ALU op encoding and
// default memory address widths.
package risc_pkg;

  localparam int XLEN        = 16;
  localparam int REG_COUNT   = 8;
  localparam int REG_AW      = 3;
  localparam int IMEM_AW_DEF = 8;
  localparam int DMEM_AW_DEF = 8;

  // Instruction field positions (LSB of each field) and widths
  localparam int RD_LSB  = 8;
  localparam int RM_LSB  = 5;
  localparam int RN_LSB  = 2;
  localparam int IMM5_W  = 5;
  localparam int IMM8_W  = 8;
  localparam int LABEL_W = 11;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_ADC,
    ALU_SBB
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } alu_flags_t;

  // Decoded op strobes to ALU op; SUB wins over SBB, SBB over ADC, else ADD.
  function automatic alu_op_e alu_op_sel(input logic sub, input logic sbb, input logic adc);
    if (sub)      return ALU_SUB;
    else if (sbb) return ALU_SBB;
    else if (adc) return ALU_ADC;
    else          return ALU_ADD;
  endfunction

endpackage

// File: rtl/risc_alu.sv
// 16-bit adder/subtractor with carry-in and C/V/Z/N flag generation.
// Subtract forms invert B and feed the carry-in, so a single adder covers
// ADD, SUB, ADC and SBB.
module risc_alu
  import risc_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  input  logic            c_in,
  output logic [XLEN-1:0] result,
  output alu_flags_t      flags
);

  logic [XLEN-1:0] b_eff;
  logic            cin_eff;
  logic [XLEN:0]   sum;

  // Operand conditioning, addition and flag derivation
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    b_eff   = b;
    cin_eff = 1'b0;
    unique case (op)
      ALU_ADD: ;
      ALU_SUB: begin b_eff = ~b; cin_eff = 1'b1; end
      ALU_ADC: cin_eff = c_in;
      ALU_SBB: begin b_eff = ~b; cin_eff = c_in; end
    endcase
    sum     = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, cin_eff};
    result  = sum[XLEN-1:0];
    flags.c = sum[XLEN];
    // Overflow: both adder inputs share a sign that the result does not.
    flags.v = (a[XLEN-1] == b_eff[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
    flags.z = (result == '0);
    flags.n = result[XLEN-1];
  end

endmodule

// File: rtl/risc_datapath.sv
// 16-bit single-cycle RISC datapath: PC, instruction memory, 8x16 register
// file, ALU, data memory and OutR, driven by decoded control strobes.
// test_normal=1 freezes execution and lets a host preload both memories.
// Optional feature macro: RISC_FLAGS_EN (registered C/V/Z/N flags; ADC/SBB
// consume the registered carry). Without it Pre_* read 0 and carry-in is 0.
module risc_datapath
  import risc_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DEF,
  parameter int DMEM_AW = DMEM_AW_DEF
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            test_normal,
  input  logic            ext_instr_we,
  input  logic [XLEN-1:0] ext_instr_addr,
  input  logic [XLEN-1:0] ext_instr_data,
  input  logic            ext_data_write_en,
  input  logic [XLEN-1:0] ext_data_addr,
  input  logic [XLEN-1:0] ext_data_data,
  input  logic            flag_HLT,
  input  logic            Src_Read_B,
  input  logic            Src_ALU_B,
  input  logic            SUB,
  input  logic            ADC,
  input  logic            SBB,
  input  logic            JMP,
  input  logic            flag_label_PC,
  input  logic            flag_Rm_PC,
  input  logic            flag_Rd_PC,
  input  logic            BRANCH,
  input  logic            data_write_en,
  input  logic            flag_mem_RF,
  input  logic            flag_ALU_RF,
  input  logic            flag_Rm_RF,
  input  logic            flag_PC_RF,
  input  logic            LHI,
  input  logic            LLI,
  input  logic            RF_write_en,
  input  logic            flag_OutR,
  output logic [XLEN-1:0] mem_instr_out,
  output logic            Pre_C,
  output logic            Pre_V,
  output logic            Pre_Z,
  output logic            Pre_N,
  output logic [XLEN-1:0] OutR
);

  logic [XLEN-1:0] pc, pc_inc, pc_next;
  logic [XLEN-1:0] rf   [REG_COUNT];
  logic [XLEN-1:0] imem [2**IMEM_AW];
  logic [XLEN-1:0] dmem [2**DMEM_AW];

  logic [XLEN-1:0]    instr;
  logic [REG_AW-1:0]  rd, rm, rn, port_b_addr;
  logic [IMM5_W-1:0]  imm5;
  logic [IMM8_W-1:0]  imm8;
  logic [LABEL_W-1:0] label;
  logic [XLEN-1:0]    port_a, port_b, rd_val, alu_b, alu_res, dmem_rdata, rf_wdata;
  logic               rf_we, run, c_in;
  alu_flags_t         alu_flags, flags_q;

  // Only the low address bits select a memory word; the opcode bits are for the control unit.
  logic unused_bits;
  assign unused_bits = ^{instr[XLEN-1:LABEL_W], ext_instr_addr[XLEN-1:IMEM_AW],
                         ext_data_addr[XLEN-1:DMEM_AW], rd_val[XLEN-1:IMM8_W]};

  assign instr         = imem[pc[IMEM_AW-1:0]];
  assign mem_instr_out = instr;

  assign rd    = instr[RD_LSB +: REG_AW];
  assign rm    = instr[RM_LSB +: REG_AW];
  assign rn    = instr[RN_LSB +: REG_AW];
  assign imm5  = instr[IMM5_W-1:0];
  assign imm8  = instr[IMM8_W-1:0];
  assign label = instr[LABEL_W-1:0];

  assign port_b_addr = Src_Read_B ? rd : rn;
  assign port_a      = rf[rm];
  assign port_b      = rf[port_b_addr];
  assign rd_val      = rf[rd];
  assign alu_b       = Src_ALU_B ? {{(XLEN-IMM5_W){1'b0}}, imm5} : port_b;
  assign dmem_rdata  = dmem[alu_res[DMEM_AW-1:0]];
  assign run         = !test_normal && flag_HLT;
  assign rf_we       = RF_write_en || LHI || LLI;
  assign pc_inc      = pc + 16'd1;

  risc_alu u_alu (
    .a      (port_a),
    .b      (alu_b),
    .op     (alu_op_sel(SUB, SBB, ADC)),
    .c_in   (c_in),
    .result (alu_res),
    .flags  (alu_flags)
  );

  // Next-PC selection: register/label jumps, then relative branch, then sequential
  always_comb begin
    pc_next = pc_inc;
    if (JMP && flag_label_PC)   pc_next = {{(XLEN-LABEL_W){1'b0}}, label};
    else if (JMP && flag_Rm_PC) pc_next = port_a;
    else if (JMP && flag_Rd_PC) pc_next = port_b;
    else if (BRANCH)            pc_next = pc + {{(XLEN-IMM8_W){imm8[IMM8_W-1]}}, imm8};
  end

  // Register-file write-data priority mux; return address is the fallback
  always_comb begin
    rf_wdata = pc_inc;
    if (LHI)              rf_wdata = {imm8, rd_val[IMM8_W-1:0]};
    else if (LLI)         rf_wdata = {{(XLEN-IMM8_W){1'b0}}, imm8};
    else if (flag_mem_RF) rf_wdata = dmem_rdata;
    else if (flag_ALU_RF) rf_wdata = alu_res;
    else if (flag_Rm_RF)  rf_wdata = port_a;
  end

  // Architectural state: PC, register file and OutR commit one instruction per edge
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clr) begin
      pc   <= '0;
      OutR <= '0;
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else if (run) begin
      pc <= pc_next;
      if (rf_we)     rf[rd] <= rf_wdata;
      if (flag_OutR) OutR   <= port_a;
    end
  end

  // Memories: host loads in test mode, stores in normal mode
  always_ff @(posedge clk) begin
    // NOTE: memory arrays have no reset; clr only blocks writes so preloaded contents survive.
    if (!clr) begin
      if (test_normal) begin
        if (ext_instr_we)      imem[ext_instr_addr[IMEM_AW-1:0]] <= ext_instr_data;
        if (ext_data_write_en) dmem[ext_data_addr[DMEM_AW-1:0]]  <= ext_data_data;
      end else if (flag_HLT && data_write_en) begin
        dmem[alu_res[DMEM_AW-1:0]] <= port_b;
      end
    end
  end

`ifdef RISC_FLAGS_EN
  // Flag register, loaded on ALU write-back instructions
  always_ff @(posedge clk) begin
    if (clr)                      flags_q <= '0;
    else if (run && flag_ALU_RF)  flags_q <= alu_flags;
  end
  assign c_in = flags_q.c;
`else
  logic unused_flags;
  assign unused_flags = ^alu_flags;
  assign flags_q      = '0;
  assign c_in         = 1'b0;
`endif

  assign {Pre_C, Pre_V, Pre_Z, Pre_N} = flags_q;

endmodule

// File: tb/tb_risc_datapath.sv
// Self-checking bench for risc_datapath: directed program checks plus a
// randomized run, both compared every cycle against a behavioural model.
module tb_risc_datapath;

  logic        clk = 1'b0;
  logic        clr, test_normal, ext_instr_we, ext_data_write_en, flag_HLT;
  logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
  logic        Src_Read_B, Src_ALU_B, SUB, ADC, SBB, JMP, flag_label_PC, flag_Rm_PC;
  logic        flag_Rd_PC, BRANCH, data_write_en, flag_mem_RF, flag_ALU_RF, flag_Rm_RF;
  logic        flag_PC_RF, LHI, LLI, RF_write_en, flag_OutR;
  logic [15:0] mem_instr_out, OutR;
  logic        Pre_C, Pre_V, Pre_Z, Pre_N;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model state
  logic [15:0] m_imem [256];
  logic [15:0] m_dmem [256];
  logic [15:0] m_rf   [8];
  logic [15:0] m_pc = '0, m_outr = '0;
  bit          m_c = 0, m_v = 0, m_z = 0, m_n = 0;

  always #5 clk = ~clk;

  risc_datapath dut (
    .clk(clk), .clr(clr), .test_normal(test_normal),
    .ext_instr_we(ext_instr_we), .ext_instr_addr(ext_instr_addr), .ext_instr_data(ext_instr_data),
    .ext_data_write_en(ext_data_write_en), .ext_data_addr(ext_data_addr), .ext_data_data(ext_data_data),
    .flag_HLT(flag_HLT), .Src_Read_B(Src_Read_B), .Src_ALU_B(Src_ALU_B),
    .SUB(SUB), .ADC(ADC), .SBB(SBB), .JMP(JMP), .flag_label_PC(flag_label_PC),
    .flag_Rm_PC(flag_Rm_PC), .flag_Rd_PC(flag_Rd_PC), .BRANCH(BRANCH),
    .data_write_en(data_write_en), .flag_mem_RF(flag_mem_RF), .flag_ALU_RF(flag_ALU_RF),
    .flag_Rm_RF(flag_Rm_RF), .flag_PC_RF(flag_PC_RF), .LHI(LHI), .LLI(LLI),
    .RF_write_en(RF_write_en), .flag_OutR(flag_OutR),
    .mem_instr_out(mem_instr_out), .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z), .Pre_N(Pre_N),
    .OutR(OutR)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: unsigned sum for carry, signed sum for overflow.
  task automatic model_alu(input logic [15:0] a, input logic [15:0] b, output logic [15:0] res,
                           output bit c, output bit v);
    int ua, ub, sa, sb, cin, u, s;
    bit inv;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    inv = SUB || SBB;
    cin = SUB ? 1 : ((SBB || ADC) ? int'(m_c) : 0);
    if (inv) begin
      u = ua - ub - 1 + cin;
      s = sa - sb - 1 + cin;
      c = (u >= 0);
    end else begin
      u = ua + ub + cin;
      s = sa + sb + cin;
      c = (u > 65535);
    end
    res = u[15:0];
    v   = (s > 32767) || (s < -32768);
  endtask

  // One clock edge of architectural behaviour, applied to the model.
  task automatic model_edge();
    logic [15:0] ins, a, bp, bo, res, wd, npc;
    logic [2:0]  rd, rm, rn;
    logic [7:0]  imm8;
    bit          c, v;
    ins  = m_imem[m_pc[7:0]];
    rd   = ins[10:8];
    rm   = ins[7:5];
    rn   = ins[4:2];
    imm8 = ins[7:0];
    a    = m_rf[rm];
    bp   = m_rf[Src_Read_B ? rd : rn];
    bo   = Src_ALU_B ? 16'(ins[4:0]) : bp;
    model_alu(a, bo, res, c, v);
    if (clr) begin
      m_pc = '0; m_outr = '0;
      m_c = 0; m_v = 0; m_z = 0; m_n = 0;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
    end else if (test_normal) begin
      if (ext_instr_we)      m_imem[ext_instr_addr[7:0]] = ext_instr_data;
      if (ext_data_write_en) m_dmem[ext_data_addr[7:0]]  = ext_data_data;
    end else if (flag_HLT) begin
      if (LHI)              wd = {imm8, m_rf[rd][7:0]};
      else if (LLI)         wd = 16'(imm8);
      else if (flag_mem_RF) wd = m_dmem[res[7:0]];
      else if (flag_ALU_RF) wd = res;
      else if (flag_Rm_RF)  wd = a;
      else                  wd = m_pc + 16'd1;
      if (JMP && flag_label_PC)   npc = 16'(ins[10:0]);
      else if (JMP && flag_Rm_PC) npc = a;
      else if (JMP && flag_Rd_PC) npc = bp;
      else if (BRANCH)            npc = 16'(int'(m_pc) + int'($signed(imm8)));
      else                        npc = m_pc + 16'd1;
      if (data_write_en) m_dmem[res[7:0]] = bp;
      if (RF_write_en || LHI || LLI) m_rf[rd] = wd;
      if (flag_OutR) m_outr = a;
`ifdef RISC_FLAGS_EN
      if (flag_ALU_RF) begin
        m_c = c; m_v = v; m_z = (res == 16'h0000); m_n = res[15];
      end
`endif
      m_pc = npc;
    end
  endtask

  task automatic ctrl_idle();
    clr = 0; test_normal = 0; flag_HLT = 1;
    ext_instr_we = 0; ext_data_write_en = 0;
    ext_instr_addr = '0; ext_instr_data = '0; ext_data_addr = '0; ext_data_data = '0;
    Src_Read_B = 0; Src_ALU_B = 0; SUB = 0; ADC = 0; SBB = 0; JMP = 0;
    flag_label_PC = 0; flag_Rm_PC = 0; flag_Rd_PC = 0; BRANCH = 0; data_write_en = 0;
    flag_mem_RF = 0; flag_ALU_RF = 0; flag_Rm_RF = 0; flag_PC_RF = 0; LHI = 0; LLI = 0;
    RF_write_en = 0; flag_OutR = 0;
  endtask

  // Model and DUT advance on the same edge; inputs change 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    tick();
    ctrl_idle();
  endtask

  task automatic host_write(input bit is_instr, input logic [15:0] addr, input logic [15:0] data);
    ctrl_idle();
    test_normal = 1;
    if (is_instr) begin
      ext_instr_we = 1; ext_instr_addr = addr; ext_instr_data = data;
    end else begin
      ext_data_write_en = 1; ext_data_addr = addr; ext_data_data = data;
    end
    step();
  endtask

  task automatic do_clr();
    ctrl_idle();
    clr = 1;
    step();
  endtask

  // Compare process: DUT outputs against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("instr_out", mem_instr_out, m_imem[m_pc[7:0]]);
      check("outr", OutR, m_outr);
      check("flags_cvzn", 16'({Pre_C, Pre_V, Pre_Z, Pre_N}), 16'({m_c, m_v, m_z, m_n}));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_idle();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;

    // Preload: address-tagged filler so the PC is visible through mem_instr_out
    for (int i = 0; i < 256; i++) host_write(1, 16'(i), 16'hF000 | 16'(i));
    for (int i = 0; i < 256; i++) host_write(0, 16'(i), 16'hD000 | 16'(i));
    host_write(0, 16'd0, 16'h1234);
    host_write(0, 16'd1, 16'h4321);
    host_write(1, 16'd0,  16'h0100);  // LDR R1,[R0,#0]
    host_write(1, 16'd1,  16'h0020);  // OUT R1
    host_write(1, 16'd2,  16'h0201);  // LDR R2,[R0,#1]
    host_write(1, 16'd3,  16'h0328);  // ADD R3,R1,R2
    host_write(1, 16'd4,  16'h0060);  // OUT R3
    host_write(1, 16'd5,  16'h0344);  // SUB R3,R2,R1
    host_write(1, 16'd6,  16'h0060);  // OUT R3
    host_write(1, 16'd7,  16'h0227);  // ADDI R2,R1,#7
    host_write(1, 16'd8,  16'h0040);  // OUT R2
    host_write(1, 16'd9,  16'h0227);  // SUBI R2,R1,#7
    host_write(1, 16'd10, 16'h0040);  // OUT R2
    host_write(1, 16'd11, 16'h0101);  // STR R1,[R0,#1]
    host_write(1, 16'd12, 16'h0201);  // LDR R2,[R0,#1]
    host_write(1, 16'd13, 16'h0040);  // OUT R2

    do_clr();
    chk_en = 1;
    check("reset_outr", OutR, 16'h0000);
    check("reset_flags", 16'({Pre_C, Pre_V, Pre_Z, Pre_N}), 16'h0000);
    check("reset_pc", mem_instr_out, 16'h0100);

    Src_ALU_B = 1; flag_mem_RF = 1; RF_write_en = 1; step();   // LDR R1
    flag_OutR = 1; step();
    check("ldr_out", OutR, 16'h1234);
    Src_ALU_B = 1; flag_mem_RF = 1; RF_write_en = 1; step();   // LDR R2
    flag_ALU_RF = 1; RF_write_en = 1; step();                  // ADD
    flag_OutR = 1; step();
    check("add_out", OutR, 16'h5555);
    SUB = 1; flag_ALU_RF = 1; RF_write_en = 1; step();         // SUB
`ifdef RISC_FLAGS_EN
    check("sub_c", 16'(Pre_C), 16'h0001);
`else
    check("sub_c", 16'(Pre_C), 16'h0000);
`endif
    check("sub_z", 16'(Pre_Z), 16'h0000);
    flag_OutR = 1; step();
    check("sub_out", OutR, 16'h30ED);
    Src_ALU_B = 1; flag_ALU_RF = 1; RF_write_en = 1; step();   // ADDI
    flag_OutR = 1; step();
    check("addi_out", OutR, 16'h123B);
    SUB = 1; Src_ALU_B = 1; flag_ALU_RF = 1; RF_write_en = 1; step();  // SUBI
    flag_OutR = 1; step();
    check("subi_out", OutR, 16'h122D);
    Src_ALU_B = 1; Src_Read_B = 1; data_write_en = 1; step();  // STR R1
    Src_ALU_B = 1; flag_mem_RF = 1; RF_write_en = 1; step();   // LDR R2
    flag_OutR = 1; step();
    check("str_ldr_out", OutR, 16'h1234);

    // Halt: everything holds even with strobes asserted
    for (int i = 0; i < 3; i++) begin
      flag_HLT = 0; flag_OutR = 1; RF_write_en = 1; flag_ALU_RF = 1; BRANCH = 1;
      data_write_en = 1;
      step();
    end
    check("hlt_pc", mem_instr_out, 16'hF00E);
    check("hlt_outr", OutR, 16'h1234);

    // clr wins over a running instruction
    clr = 1; flag_OutR = 1; RF_write_en = 1; BRANCH = 1; step();
    check("clr_pc", mem_instr_out, 16'h0100);
    check("clr_outr", OutR, 16'h0000);

    // JAL1 at PC=1, imm8=7 -> PC=8, R2 = 2
    host_write(1, 16'd1, 16'h0207);
    step();
    BRANCH = 1; flag_PC_RF = 1; RF_write_en = 1; step();
    check("jal1_pc", mem_instr_out, 16'h0040);
    flag_OutR = 1; step();
    check("jal1_link", OutR, 16'h0002);

    // JMP label=8 at PC=1
    do_clr();
    step();
    host_write(1, 16'd1, 16'h0008);
    JMP = 1; flag_label_PC = 1; step();
    check("jmp_label_pc", mem_instr_out, 16'h0040);

    // JAL2 through R1 = 0x12
    do_clr();
    host_write(1, 16'd0, 16'h0112);  // LLI R1,#0x12
    host_write(1, 16'd1, 16'h0720);  // JAL2 R7,R1
    LLI = 1; step();
    JMP = 1; flag_Rm_PC = 1; flag_PC_RF = 1; RF_write_en = 1; step();
    check("jal2_pc", mem_instr_out, 16'hF012);

    // JR through R[Rd] with Rd = 1
    do_clr();
    host_write(1, 16'd1, 16'h0100);
    LLI = 1; step();
    JMP = 1; flag_Rd_PC = 1; Src_Read_B = 1; step();
    check("jr_pc", mem_instr_out, 16'hF012);

    // Randomized run against the model
    for (int i = 0; i < 256; i++) host_write(1, 16'(i), 16'($urandom));
    for (int i = 0; i < 256; i++) host_write(0, 16'(i), 16'($urandom));
    do_clr();
    for (int i = 0; i < 2000; i++) begin
      clr               = ($urandom_range(63) == 0);
      test_normal       = ($urandom_range(15) == 0);
      flag_HLT          = ($urandom_range(15) != 0);
      ext_instr_we      = 1'($urandom);
      ext_instr_addr    = 16'($urandom);
      ext_instr_data    = 16'($urandom);
      ext_data_write_en = 1'($urandom);
      ext_data_addr     = 16'($urandom);
      ext_data_data     = 16'($urandom);
      Src_Read_B = 1'($urandom); Src_ALU_B = 1'($urandom);
      SUB = ($urandom_range(3) == 0); ADC = 1'($urandom); SBB = 1'($urandom);
      JMP = ($urandom_range(3) == 0);
      flag_label_PC = 1'($urandom); flag_Rm_PC = 1'($urandom); flag_Rd_PC = 1'($urandom);
      BRANCH = ($urandom_range(3) == 0); data_write_en = 1'($urandom);
      flag_mem_RF = 1'($urandom); flag_ALU_RF = 1'($urandom); flag_Rm_RF = 1'($urandom);
      flag_PC_RF = 1'($urandom); LHI = ($urandom_range(7) == 0); LLI = ($urandom_range(7) == 0);
      RF_write_en = 1'($urandom); flag_OutR = 1'($urandom);
      tick();
    end
    ctrl_idle();
    @(negedge clk);
    #1;
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
